// File: rtl/mem_access.sv
// Byte-serial load/store unit between the EX/MEM register and the 8-bit RAM port.
// Loads return a sign/zero-extended result; stores write N bytes little-endian.
module mem_access (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_val_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [7:0]  ram_din_in,
  output logic [7:0]  ram_dout_out,
  output logic [31:0] ram_a_out,
  output logic        ram_wr_out,
  output logic [31:0] rd_val_out,
  output logic        done_out,
  output logic        stallreq_from_mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic [31:0] rd_val_q, rd_val_d;
  logic        done_q, done_d;

  logic [2:0]  last_idx;
  logic [2:0]  cnt_n;
  logic [1:0]  lane;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {{24{v[7]  & ~uns}}, v[7:0]};
      2'd1:    r = {{16{v[15] & ~uns}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    size_d     = size_q;
    uns_d      = uns_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ram_a_d    = 32'd0;
    ram_wr_d   = 1'b0;
    ram_dout_d = ram_dout_q;
    rd_val_d   = rd_val_q;
    done_d     = 1'b0;

    case (size_q)
      2'd0:    last_idx = 3'd0;
      2'd1:    last_idx = 3'd1;
      default: last_idx = 3'd3;
    endcase
    cnt_n = cnt_q + 3'd1;
    // In LOAD cycle k the RAM returns the byte addressed in cycle k-1.
    lane  = cnt_q[1:0] - 2'd1;

    case (state_q)
      S_IDLE: begin
        if (load_in || store_in) begin
          addr_d  = mem_addr_in;
          data_d  = mem_val_in;
          size_d  = size_in;
          uns_d   = unsigned_in;
          cnt_d   = 3'd0;
          acc_d   = 32'd0;
          ram_a_d = mem_addr_in;
          if (store_in) begin
            state_d    = S_STORE;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_val_in[7:0];
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (cnt_q != 3'd0) acc_d[{lane, 3'b000} +: 8] = ram_din_in;
        if (cnt_q == last_idx + 3'd1) begin
          rd_val_d = extend(acc_d, size_q, uns_q);
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_n;
          if (cnt_q < last_idx) ram_a_d = addr_q + {29'd0, cnt_n};
        end
      end

      S_STORE: begin
        if (cnt_q == last_idx) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d      = cnt_n;
          ram_wr_d   = 1'b1;
          ram_a_d    = addr_q + {29'd0, cnt_n};
          ram_dout_d = data_q[{cnt_n[1:0], 3'b000} +: 8];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst_in) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      cnt_q      <= 3'd0;
      acc_q      <= 32'd0;
      ram_a_q    <= 32'd0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= 8'd0;
      rd_val_q   <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ram_a_q    <= ram_a_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
      rd_val_q   <= rd_val_d;
      done_q     <= done_d;
    end
  end

  assign ram_a_out         = ram_a_q;
  assign ram_wr_out        = ram_wr_q;
  assign ram_dout_out      = ram_dout_q;
  assign rd_val_out        = rd_val_q;
  assign done_out          = done_q;
  assign stallreq_from_mem = (load_in | store_in) & ~done_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a byte RAM model, a per-cycle driver and a
// scoreboard monitor that checks completion cycle and load result on done_out.
module tb_mem_access;

  logic        clk;
  logic        rst_in;
  logic        load_in;
  logic        store_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_val_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic [7:0]  ram_din_in;
  logic [7:0]  ram_dout_out;
  logic [31:0] ram_a_out;
  logic        ram_wr_out;
  logic [31:0] rd_val_out;
  logic        done_out;
  logic        stallreq_from_mem;

  mem_access dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .load_in           (load_in),
    .store_in          (store_in),
    .mem_addr_in       (mem_addr_in),
    .mem_val_in        (mem_val_in),
    .size_in           (size_in),
    .unsigned_in       (unsigned_in),
    .ram_din_in        (ram_din_in),
    .ram_dout_out      (ram_dout_out),
    .ram_a_out         (ram_a_out),
    .ram_wr_out        (ram_wr_out),
    .rd_val_out        (rd_val_out),
    .done_out          (done_out),
    .stallreq_from_mem (stallreq_from_mem)
  );

  typedef struct {
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] last_rd  = 32'd0;
  logic [7:0]  mem [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data appears one cycle after its address.
  always @(posedge clk) begin
    ram_din_in <= mem.exists(ram_a_out) ? mem[ram_a_out] : 8'h00;
    if (ram_wr_out) mem[ram_a_out] = ram_dout_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_in && done_out) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("rd_val", rd_val_out, e.rd);
      end
    end
  end

  // Issue one request at the current cycle (T0), check the RAM port cycle by
  // cycle, and release the request in the IDLE cycle after done.
  task automatic run_req(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] val, input logic [1:0] sz, input logic uns,
                         input logic [31:0] exp_val);
    int   n;
    int   lat;
    exp_t e;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lat = st ? n + 1 : n + 2;
    load_in     = ld;
    store_in    = st;
    mem_addr_in = addr;
    mem_val_in  = val;
    size_in     = sz;
    unsigned_in = uns;
    e.rd  = st ? last_rd : exp_val;
    e.cyc = cyc + lat;
    sb.push_back(e);
    if (!st) last_rd = exp_val;
    #1 check("stall_t0", {31'd0, stallreq_from_mem}, 32'd1);
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      #1;
      if (j <= n) begin
        check("ram_addr", ram_a_out, addr + 32'(j - 1));
        check("ram_wr", {31'd0, ram_wr_out}, {31'd0, st});
        if (st) check("ram_dout", {24'd0, ram_dout_out}, {24'd0, val[8*(j-1) +: 8]});
      end else begin
        check("ram_wr_idle", {31'd0, ram_wr_out}, 32'd0);
      end
      if (j < lat) begin
        check("stall_busy", {31'd0, stallreq_from_mem}, 32'd1);
      end else begin
        check("stall_done", {31'd0, stallreq_from_mem}, 32'd0);
        check("done_pulse", {31'd0, done_out}, 32'd1);
      end
    end
    @(negedge clk);
    load_in  = 1'b0;
    store_in = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in      = 1'b1;
    load_in     = 1'b0;
    store_in    = 1'b0;
    mem_addr_in = 32'd0;
    mem_val_in  = 32'd0;
    size_in     = 2'd0;
    unsigned_in = 1'b0;
    mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56;
    mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
    mem[32'h2000] = 8'h80;
    mem[32'h3000] = 8'hFE; mem[32'h3001] = 8'hFF;
    mem[32'h4001] = 8'h11; mem[32'h4002] = 8'h22; mem[32'h4003] = 8'h33;
    mem[32'h0001] = 8'h01; mem[32'h0002] = 8'h02;

    idle(3);
    #1;
    check("rst_ram_a", ram_a_out, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr_out}, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout_out}, 32'd0);
    check("rst_rd_val", rd_val_out, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_stall", {31'd0, stallreq_from_mem}, 32'd0);
    @(negedge clk);
    rst_in = 1'b0;

    run_req(1, 0, 32'h0000_1000, 32'd0, 2'd2, 0, 32'h1234_5678);   // LW
    idle(1);
    run_req(1, 0, 32'h0000_2000, 32'd0, 2'd0, 0, 32'hFFFF_FF80);   // LB
    run_req(1, 0, 32'h0000_2000, 32'd0, 2'd0, 1, 32'h0000_0080);   // LBU
    run_req(1, 0, 32'h0000_3000, 32'd0, 2'd1, 0, 32'hFFFF_FFFE);   // LH
    run_req(1, 0, 32'h0000_3000, 32'd0, 2'd1, 1, 32'h0000_FFFE);   // LHU
    idle(2);
    run_req(0, 1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 2'd1, 0, 32'd0);   // SH wrapping
    run_req(1, 0, 32'hFFFF_FFFF, 32'd0, 2'd2, 0, 32'h0201_BEEF);   // LW wrapping readback
    idle(2);
    run_req(0, 1, 32'h0000_4000, 32'h0000_00A5, 2'd0, 0, 32'd0);   // SB
    run_req(1, 0, 32'h0000_4000, 32'd0, 2'd2, 0, 32'h3322_11A5);   // LW back-to-back
    idle(1);
    run_req(1, 1, 32'h0000_5000, 32'h0BAD_F00D, 2'd2, 0, 32'd0);   // both high -> store
    run_req(1, 0, 32'h0000_5000, 32'd0, 2'd3, 1, 32'h0BAD_F00D);   // size 3 reads a word
    idle(2);

    // SW interrupted by reset in T2, then restarted with the request still held.
    load_in     = 1'b0;
    store_in    = 1'b1;
    mem_addr_in = 32'h0000_6000;
    mem_val_in  = 32'hCAFE_BABE;
    size_in     = 2'd2;
    unsigned_in = 1'b0;
    @(negedge clk);
    #1 check("abort_t1_wr", {31'd0, ram_wr_out}, 32'd1);
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    #1;
    check("abort_ram_wr", {31'd0, ram_wr_out}, 32'd0);
    check("abort_ram_a", ram_a_out, 32'd0);
    check("abort_done", {31'd0, done_out}, 32'd0);
    check("abort_rd_val", rd_val_out, 32'd0);
    last_rd = 32'd0;
    rst_in  = 1'b0;
    run_req(0, 1, 32'h0000_6000, 32'hCAFE_BABE, 2'd2, 0, 32'd0);
    run_req(1, 0, 32'h0000_6000, 32'd0, 2'd2, 0, 32'hCAFE_BABE);

    idle(4);
    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
